// File: rtl/bram_pipeline_control_fsm.sv
// Frame sequencer for a chain of BRAM pipeline stages rotating through NUM_BUFS frame buffers.
// Stages join one per frame as the pipeline fills; each frame waits for start acks and then for all stages to go idle.
module bram_pipeline_control_fsm #(
    parameter int NUM_STAGES    = 3,
    parameter int NUM_BUFS      = 2,
    parameter int START_TIMEOUT = 1024,
    parameter int CNT_W         = 16,
    parameter int IDX_W         = $clog2(NUM_BUFS)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        enable_i,
    input  logic [NUM_STAGES-1:0]       stage_idle_i,
    output logic [NUM_STAGES-1:0]       stage_start_o,
    output logic [NUM_STAGES*IDX_W-1:0] stage_index_o,
    output logic [NUM_STAGES-1:0]       stage_enabled_o,
    output logic [CNT_W-1:0]            frame_count_o,
    output logic                        timeout_err_o,
    output logic                        busy_o
);

    localparam int WD_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0);
    localparam logic [NUM_STAGES-1:0] FILL_RST = NUM_STAGES'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_DONE
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        head_q, head_d;
    logic [NUM_STAGES-1:0]   fill_q, fill_d;
    logic [NUM_STAGES-1:0]   seen_q, seen_d;
    logic [NUM_STAGES-1:0]   active;
    logic [WD_W-1:0]         wdog_q;
    logic [CNT_W-1:0]        count_q;
    logic                    err_q;
    logic                    all_acked, wdog_fire, all_idle;

    always_comb begin
        active    = fill_q & ~stage_idle_i;
        seen_d    = seen_q | active;
        all_acked = ((seen_d & fill_q) == fill_q);
        wdog_fire = (START_TIMEOUT != 0) && (wdog_q == WD_LAST);
        all_idle  = (active == '0);
        head_d    = (head_q == IDX_W'(NUM_BUFS - 1)) ? '0 : head_q + IDX_W'(1);
        // shifting a one in saturates naturally once every stage is filled
        fill_d    = {fill_q[NUM_STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            head_q  <= '0;
            fill_q  <= FILL_RST;
            seen_q  <= '0;
            wdog_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable_i) begin
                        state_q <= ST_START;
                        seen_q  <= '0;
                        wdog_q  <= '0;
                    end
                end
                ST_START: begin
                    seen_q <= seen_d;
                    wdog_q <= wdog_q + WD_W'(1);
                    // a last ack coinciding with the watchdog wins: no error flagged
                    if (all_acked) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (wdog_fire) begin
                        state_q <= ST_WAIT_DONE;
                        err_q   <= 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (all_idle) begin
                        head_q  <= head_d;
                        fill_q  <= fill_d;
                        count_q <= count_q + CNT_W'(1);
                        seen_q  <= '0;
                        wdog_q  <= '0;
                        state_q <= enable_i ? ST_START : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stage_index_o = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            stage_index_o[s*IDX_W +: IDX_W] =
                IDX_W'((int'(head_q) + NUM_BUFS - (s % NUM_BUFS)) % NUM_BUFS);
        end
    end

    assign stage_start_o   = (state_q == ST_START) ? (fill_q & ~seen_q) : '0;
    assign stage_enabled_o = fill_q;
    assign frame_count_o   = count_q;
    assign timeout_err_o   = err_q;
    assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bram_pipeline_control_fsm.sv
// Bench for bram_pipeline_control_fsm: two configurations driven by a timeline-based stage emulator.
// Expected outputs come from per-frame event times (ack, watchdog, all-idle) rather than the FSM itself.
module tb_bram_pipeline_control_fsm;

    localparam int A_NS = 3, A_NB = 2, A_TO = 16, A_CW = 4;
    localparam int B_NS = 4, B_NB = 4, B_TO = 0,  B_CW = 16;

    logic clk = 1'b0;
    logic rst;

    logic        en_a, err_a, busy_a;
    logic [2:0]  idle_a, start_a, ena_a, idx_a;
    logic [3:0]  cnt_a;
    logic        en_b, err_b, busy_b;
    logic [3:0]  idle_b, start_b, ena_b;
    logic [7:0]  idx_b;
    logic [15:0] cnt_b;

    bram_pipeline_control_fsm #(
        .NUM_STAGES(A_NS), .NUM_BUFS(A_NB), .START_TIMEOUT(A_TO), .CNT_W(A_CW)
    ) dut_a (
        .clk_i(clk), .reset_i(rst), .enable_i(en_a), .stage_idle_i(idle_a),
        .stage_start_o(start_a), .stage_index_o(idx_a), .stage_enabled_o(ena_a),
        .frame_count_o(cnt_a), .timeout_err_o(err_a), .busy_o(busy_a)
    );

    bram_pipeline_control_fsm #(
        .NUM_STAGES(B_NS), .NUM_BUFS(B_NB), .START_TIMEOUT(B_TO), .CNT_W(B_CW)
    ) dut_b (
        .clk_i(clk), .reset_i(rst), .enable_i(en_b), .stage_idle_i(idle_b),
        .stage_start_o(start_b), .stage_index_o(idx_b), .stage_enabled_o(ena_b),
        .frame_count_o(cnt_b), .timeout_err_o(err_b), .busy_o(busy_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int sel, ns, nb, to, cw;
    logic [3:0] o_start, o_en;
    int         o_idx[4];
    int         o_cnt;
    logic       o_err, o_busy;

    int   head_m, fill_m, cnt_m;
    logic err_m;

    task automatic model_reset();
        head_m = 0; fill_m = 1; cnt_m = 0; err_m = 1'b0;
    endtask

    task automatic set_cfg(input int which);
        sel = which;
        if (which == 0) begin ns = A_NS; nb = A_NB; to = A_TO; cw = A_CW; end
        else            begin ns = B_NS; nb = B_NB; to = B_TO; cw = B_CW; end
        model_reset();
    endtask

    task automatic read();
        if (sel == 0) begin
            o_start = {1'b0, start_a}; o_en = {1'b0, ena_a};
            for (int s = 0; s < 3; s++) o_idx[s] = int'(idx_a[s]);
            o_idx[3] = 0;
            o_cnt = int'(cnt_a); o_err = err_a; o_busy = busy_a;
        end else begin
            o_start = start_b; o_en = ena_b;
            for (int s = 0; s < 4; s++) o_idx[s] = int'(idx_b[2*s +: 2]);
            o_cnt = int'(cnt_b); o_err = err_b; o_busy = busy_b;
        end
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
        read();
    endtask

    task automatic drive_en(input logic v);
        if (sel == 0) en_a = v; else en_b = v;
    endtask

    task automatic drive_idle(input logic [3:0] v);
        if (sel == 0) idle_a = v[2:0]; else idle_b = v;
    endtask

    // One frame from its first ST_START sample to the sample after completion.
    // Stage s goes busy d[s] cycles after start for r[s] cycles; mute stages never respond.
    task automatic do_frame(input int d[4], input int r[4], input logic [3:0] mute,
                            input logic en_next, input string tag);
        logic [3:0] fm, busyv, exp_st;
        logic       exp_err, any_mute;
        int         max_d, t_w, tc;
        fm = fill_m[3:0];
        checks++;
        if (o_start !== fm) begin failures++; $display("FAIL %s first_start act=%b exp=%b", tag, o_start, fm); end
        checks++;
        if (o_en !== fm) begin failures++; $display("FAIL %s enabled act=%b exp=%b", tag, o_en, fm); end
        for (int s = 0; s < ns; s++) begin
            checks++;
            if (o_idx[s] !== ((head_m - s) % nb + nb) % nb) begin
                failures++;
                $display("FAIL %s index s%0d act=%0d exp=%0d", tag, s, o_idx[s], ((head_m - s) % nb + nb) % nb);
            end
        end
        checks++;
        if (o_cnt !== cnt_m) begin failures++; $display("FAIL %s count act=%0d exp=%0d", tag, o_cnt, cnt_m); end

        max_d = 0; any_mute = 1'b0;
        for (int s = 0; s < ns; s++) begin
            if (fm[s]) begin
                if (mute[s]) any_mute = 1'b1;
                else if (d[s] > max_d) max_d = d[s];
            end
        end
        t_w = max_d; exp_err = err_m;
        if (to != 0 && (any_mute || max_d > to - 1)) begin
            t_w = to - 1; exp_err = 1'b1;
        end

        drive_en(en_next);
        tc = -1;
        for (int k = 0; k < 300 && tc < 0; k++) begin
            if (k > 0) begin
                sample();
                exp_st = '0;
                for (int s = 0; s < ns; s++)
                    exp_st[s] = fm[s] && (k <= t_w) && (mute[s] || k <= d[s]);
                checks++;
                if (o_start !== exp_st) begin failures++; $display("FAIL %s start k=%0d act=%b exp=%b", tag, k, o_start, exp_st); end
                checks++;
                if (o_busy !== 1'b1) begin failures++; $display("FAIL %s busy k=%0d act=%b exp=1", tag, k, o_busy); end
                checks++;
                if (o_err !== ((k > t_w) ? exp_err : err_m)) begin
                    failures++;
                    $display("FAIL %s timeout_err k=%0d act=%b exp=%b", tag, k, o_err, (k > t_w) ? exp_err : err_m);
                end
            end
            busyv = '0;
            for (int s = 0; s < ns; s++) begin
                if (fm[s]) busyv[s] = !mute[s] && (k >= d[s]) && (k < d[s] + r[s]);
                else       busyv[s] = 1'($urandom_range(0, 1));
            end
            drive_idle(~busyv);
            if (k >= t_w + 1 && (busyv & fm) == '0) tc = k;
        end
        checks++;
        if (tc < 0) begin
            failures++; $display("FAIL %s completion act=none exp=within_300", tag);
            return;
        end

        sample();
        head_m = (head_m + 1) % nb;
        fill_m = ((fill_m << 1) | 1) & ((1 << ns) - 1);
        cnt_m  = (cnt_m + 1) % (1 << cw);
        err_m  = exp_err;
        checks++;
        if (o_cnt !== cnt_m) begin failures++; $display("FAIL %s count_done act=%0d exp=%0d", tag, o_cnt, cnt_m); end
        checks++;
        if (o_busy !== en_next) begin failures++; $display("FAIL %s busy_done act=%b exp=%b", tag, o_busy, en_next); end
        checks++;
        if (o_start !== (en_next ? fill_m[3:0] : 4'h0)) begin
            failures++; $display("FAIL %s next_start act=%b exp=%b", tag, o_start, en_next ? fill_m[3:0] : 4'h0);
        end
        checks++;
        if (o_en !== fill_m[3:0]) begin failures++; $display("FAIL %s fill_done act=%b exp=%b", tag, o_en, fill_m[3:0]); end
    endtask

    task automatic kick(input string tag);
        drive_en(1'b1);
        drive_idle(4'hF);
        sample();
        checks++;
        if (o_start !== fill_m[3:0] || o_busy !== 1'b1) begin
            failures++; $display("FAIL %s kick start=%b busy=%b exp_start=%b", tag, o_start, o_busy, fill_m[3:0]);
        end
    endtask

    task automatic test_reset();
        set_cfg(0);
        read();
        checks++;
        if (o_start !== 4'h0 || o_busy !== 1'b0) begin failures++; $display("FAIL reset start=%b busy=%b exp=0/0", o_start, o_busy); end
        checks++;
        if (o_en !== 4'b0001) begin failures++; $display("FAIL reset enabled act=%b exp=0001", o_en); end
        checks++;
        if (o_idx[0] !== 0 || o_idx[1] !== 1 || o_idx[2] !== 0) begin
            failures++; $display("FAIL reset index act=%0d%0d%0d exp=010", o_idx[0], o_idx[1], o_idx[2]);
        end
        checks++;
        if (o_cnt !== 0 || o_err !== 1'b0) begin failures++; $display("FAIL reset cnt/err act=%0d/%b exp=0/0", o_cnt, o_err); end
        drive_en(1'b1);
        sample();
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_hold busy act=%b exp=0", o_busy); end
        drive_en(1'b0);
        rst = 1'b0;
        sample();
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL idle_no_enable busy act=%b exp=0", o_busy); end
    endtask

    task automatic test_fill_default();
        logic [3:0] masks[3];
        masks[0] = 4'b0001; masks[1] = 4'b0011; masks[2] = 4'b0111;
        kick("fill");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_en !== masks[i]) begin failures++; $display("FAIL fill_mask f%0d act=%b exp=%b", i, o_en, masks[i]); end
            do_frame('{3, 3, 3, 3}, '{20, 20, 20, 20}, 4'b0000, 1'b1, "fill");
        end
    endtask

    task automatic test_random_frames(input int n, input logic last_en, input string tag);
        int d[4], r[4];
        for (int i = 0; i < n; i++) begin
            for (int s = 0; s < 4; s++) begin
                d[s] = $urandom_range(0, 5);
                r[s] = $urandom_range(1, 8);
            end
            do_frame(d, r, 4'b0000, (i == n - 1) ? last_en : 1'b1, tag);
        end
    endtask

    task automatic test_pause();
        do_frame('{2, 1, 0, 0}, '{5, 6, 7, 1}, 4'b0000, 1'b0, "pause");
        for (int i = 0; i < 4; i++) begin
            sample();
            checks++;
            if (o_busy !== 1'b0 || o_start !== 4'h0 || o_en !== fill_m[3:0]) begin
                failures++;
                $display("FAIL paused busy=%b start=%b en=%b exp_en=%b", o_busy, o_start, o_en, fill_m[3:0]);
            end
        end
        kick("resume");
        test_random_frames(1, 1'b1, "resume");
    endtask

    task automatic test_reset_midframe();
        kick("rst_mid");
        drive_idle(~fill_m[3:0]);
        sample(); sample(); sample();
        #1 rst = 1'b1;
        #1 read();
        model_reset();
        checks++;
        if (o_start !== 4'h0 || o_busy !== 1'b0 || o_en !== 4'b0001) begin
            failures++; $display("FAIL async_reset start=%b busy=%b en=%b exp=0/0/0001", o_start, o_busy, o_en);
        end
        checks++;
        if (o_cnt !== 0 || o_err !== 1'b0 || o_idx[1] !== 1 || o_idx[0] !== 0) begin
            failures++; $display("FAIL async_reset cnt=%0d err=%b idx0=%0d idx1=%0d exp=0/0/0/1", o_cnt, o_err, o_idx[0], o_idx[1]);
        end
        sample();
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_dominates busy act=%b exp=0", o_busy); end
        drive_en(1'b0);
        drive_idle(4'hF);
        rst = 1'b0;
        sample();
        kick("after_rst");
        test_random_frames(2, 1'b0, "after_rst");
    endtask

    task automatic test_four_stage();
        set_cfg(1);
        kick("four");
        test_random_frames(8, 1'b0, "four");
        checks++;
        if (o_en !== 4'b1111) begin failures++; $display("FAIL four_saturate act=%b exp=1111", o_en); end
    endtask

    initial begin
        rst = 1'b1;
        en_a = 1'b0; en_b = 1'b0;
        idle_a = 3'b111; idle_b = 4'hF;
        sel = 0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_fill_default();
        do_frame('{0, 2, 8, 0}, '{2, 3, 4, 1}, 4'b0000, 1'b1, "stagger");
        do_frame('{1, 2, 15, 0}, '{3, 3, 3, 1}, 4'b0000, 1'b1, "ack_edge");
        do_frame('{1, 0, 2, 0}, '{4, 4, 4, 1}, 4'b0010, 1'b1, "timeout");
        test_pause();
        test_random_frames(12, 1'b0, "random");
        test_reset_midframe();
        test_four_stage();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_pipeline_control_fsm.md
# bram_pipeline_control_fsm

Parametrised frame-sequencing controller for the depth-filter BRAM pipeline. It generalises the two-buffer ping-pong scheme to NUM_STAGES chained stages rotating through NUM_BUFS frame buffers. Each stage is started only once the pipeline has filled far enough to give it valid data. The block adds per-stage start acknowledgement, a start watchdog, enable/pause control and a frame counter. It sits above the BRAM writers, filter read/write engines and output readers, replacing the fixed three-client controller.

## Interface
- NUM_STAGES, 3, number of pipeline stages (≥2); stage 0 is the input writer, stage NUM_STAGES-1 the output reader
- NUM_BUFS, 2, number of frame buffers (≥2)
- START_TIMEOUT, 1024, cycles allowed for all enabled stages to go busy after start; 0 disables the watchdog
- CNT_W, 16, frame counter width
- IDX_W, $clog2(NUM_BUFS), derived buffer-index width; not overridden
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run permission; sampled in ST_IDLE and at frame completion
- stage_idle  in  NUM_STAGES  per-stage idle status, bit s = stage s
- stage_start  out  NUM_STAGES  per-stage start request (level)
- stage_index  out  NUM_STAGES*IDX_W  buffer index for stage s at bits [s*IDX_W +: IDX_W]
- stage_enabled  out  NUM_STAGES  fill mask; bit s = stage s participates this frame
- frame_count  out  CNT_W  completed frames, wraps
- timeout_err  out  1  sticky watchdog flag
- busy  out  1  high when state ≠ ST_IDLE

## Operation
- Registers:
  - head: IDX_W, reset 0
  - fill: NUM_STAGES, reset 0...01
  - seen: NUM_STAGES, reset 0
  - wdog counter, reset 0
  - frame_count, reset 0
  - timeout_err, reset 0
  - state, reset ST_IDLE
- stage_index[s] = (head + NUM_BUFS − (s mod NUM_BUFS)) mod NUM_BUFS. With NUM_BUFS=2, NUM_STAGES=3 at reset, the indices are 0, 1, 0.
- stage_enabled = fill. stage_start[s] = (state==ST_START) && fill[s] && !seen[s]. All combinational from registers.
- In ST_START, seen[s] sets on any cycle with fill[s] && !stage_idle[s]. The latch makes it unnecessary for all stages to be busy simultaneously.
- States:
  - ST_IDLE: if enable, go to ST_START and clear seen and wdog.
  - ST_START: wdog increments each cycle. Go to ST_WAIT_DONE when (seen | stage going busy this cycle) covers fill. Also go to ST_WAIT_DONE when START_TIMEOUT≠0 and wdog reaches START_TIMEOUT−1; this sets timeout_err.
  - ST_WAIT_DONE: when every stage with fill[s] is idle, the frame completes:
    - head ← (head+1) mod NUM_BUFS
    - fill ← {fill[NUM_STAGES-2:0], 1'b1}
    - frame_count ← frame_count+1
    - seen ← 0, wdog ← 0
    - next state is ST_START if enable, else ST_IDLE
- A stage with fill[s]=0 is ignored for start, acknowledgement and completion.
- fill saturates at all-ones. It is preserved across pause (enable low), so a resumed pipeline does not refill.
- timeout_err clears only on reset.

## Timing
- All outputs are at their reset values while reset is high:
  - stage_start 0, busy 0, stage_enabled 0...01, stage_index per head=0, frame_count 0, timeout_err 0.
- Reset asserted mid-frame aborts immediately to the reset values, with no completion and no count increment.
- First stage_start rises 1 cycle after the first clk edge with enable high in ST_IDLE.
- A start bit drops the cycle after that stage's idle is seen low.
- The ST_WAIT_DONE→ST_START edge updates head, fill and count, and raises the next stage_start 1 cycle after all enabled stages are idle. No gap cycle is inserted.
- A stage going busy and idle in the same ST_START window still counts as acknowledged.
- A timeout that fires on the same cycle as the last acknowledgement: the transition is taken and timeout_err is not set.
- frame_count wraps from 2^CNT_W−1 to 0.

## Test plan
- Defaults, all stages respond 3 cycles after start and run 20 cycles → frames 0/1/2 start masks 001/011/111. Indices (s0,s1,s2) follow (0,1,0), (1,0,1), (0,1,0). frame_count 1, 2, 3.
- NUM_STAGES=4, NUM_BUFS=4 → after fill, stage indices at head=h are h, h−1, h−2, h−3 mod 4, all distinct. fill saturates at 1111.
- Staggered acknowledgement: stage 0 finishes before stage 2 goes busy → still reaches ST_WAIT_DONE. No deadlock.
- Stage 1 never leaves idle, START_TIMEOUT=16 → timeout_err is set 16 cycles after entering ST_START, and the FSM proceeds to ST_WAIT_DONE and continues.
- enable deasserted mid-frame → the current frame completes and the FSM goes to ST_IDLE with busy 0 and fill kept. Re-enabling restarts with the same fill mask and the next head.
- Reset pulse during ST_WAIT_DONE → all outputs return to their reset values asynchronously. The next run begins with mask 001 and indices (0,1,0).
